// File: rtl/dir_input_ctrl.sv
// dir_input_ctrl: debounced direction buttons feeding a 2-deep turn queue committed on each game step
module dir_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 20,
  parameter logic [1:0] RESET_DIR = 2'b01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       right,
  input  logic       down,
  input  logic       left,
  input  logic       step,
  output logic [1:0] dir,
  output logic       dir_changed,
  output logic       started,
  output logic [3:0] btn_level,
  output logic [1:0] q_count
);
  logic [3:0] raw, s1, s2, prev, press;
  logic [CNT_W-1:0] cnt [4];
  logic [1:0] q0, q1, p, r, n_cnt;
  logic pop, acc;
  assign raw = {left, down, right, up};
  assign press = btn_level & ~prev;
  // two-flop synchronizer plus previous-level register for press edges
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      prev <= btn_level;
    end
  end
  // per-button debounce: level flips only after the synced input differs long enough
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        cnt[i] <= '0;
        btn_level[i] <= 1'b0;
      end else if (s2[i] == btn_level[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt[i] <= '0;
        btn_level[i] <= ~btn_level[i];
      end else begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
  // pick the highest-priority press and decide whether it is a legal turn
  always_comb begin
    p = press[0] ? 2'd0 : press[1] ? 2'd1 : press[2] ? 2'd2 : 2'd3;
    pop = step && q_count != 2'd0;
    r = q_count == 2'd0 ? dir : q_count == 2'd1 ? q0 : q1;
    n_cnt = q_count - {1'b0, pop};
    acc = |press && p != r && p != (r ^ 2'b10) && n_cnt != 2'd2;
  end
  // turn queue: pop to dir on step, then append an accepted press behind what remains
  always_ff @(posedge clk) begin
    if (rst) begin
      dir <= RESET_DIR;
      dir_changed <= 1'b0;
      started <= 1'b0;
      q_count <= '0;
      q0 <= '0;
      q1 <= '0;
    end else begin
      dir_changed <= pop;
      if (pop) begin
        dir <= q0;
        q0 <= q1;
      end
      if (acc) begin
        started <= 1'b1;
        if (n_cnt == 2'd0) q0 <= p;
        else q1 <= p;
      end
      q_count <= n_cnt + {1'b0, acc};
    end
  end
endmodule

// File: tb/tb_dir_input_ctrl.sv
// tb_dir_input_ctrl: directed and random stimulus checked against a queue-based reference model
module tb_dir_input_ctrl;
  localparam int DEB = 4;
  logic clk = 0, rst = 1, step = 0;
  logic [3:0] btn = '0;
  logic [1:0] dir, q_count;
  logic dir_changed, started;
  logic [3:0] btn_level;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;
  dir_input_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3), .RESET_DIR(2'b01)) dut (
    .clk(clk), .rst(rst), .up(btn[0]), .right(btn[1]), .down(btn[2]), .left(btn[3]),
    .step(step), .dir(dir), .dir_changed(dir_changed), .started(started),
    .btn_level(btn_level), .q_count(q_count)
  );
  always #5 clk = ~clk;
  // reference model state
  logic [3:0] h1 = '0, h2 = '0, m_lvl = '0, m_prev = '0;
  int run [4] = '{0, 0, 0, 0};
  logic [1:0] m_dir = 2'b01;
  bit m_chg = 0, m_started = 0;
  logic [1:0] mq[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  // model: synced input must differ for DEB consecutive samples to flip a level;
  // a rising level yields a press one cycle later; legal turns go into a 2-deep queue
  always @(posedge clk) begin
    logic [3:0] ev;
    logic [1:0] r, p;
    if (rst) begin
      h1 = '0; h2 = '0; m_lvl = '0; m_prev = '0;
      for (int i = 0; i < 4; i++) run[i] = 0;
      m_dir = 2'b01; m_chg = 0; m_started = 0;
      mq.delete();
    end else begin
      ev = m_lvl & ~m_prev;
      r = mq.size() > 0 ? mq[mq.size()-1] : m_dir;
      m_chg = 0;
      if (step && mq.size() > 0) begin
        m_dir = mq.pop_front();
        m_chg = 1;
      end
      if (ev != 0) begin
        p = 0;
        for (int i = 3; i >= 0; i--) if (ev[i]) p = 2'(i);
        if (p != r && p != (r ^ 2'b10) && mq.size() < 2) begin
          mq.push_back(p);
          m_started = 1;
        end
      end
      m_prev = m_lvl;
      for (int i = 0; i < 4; i++) begin
        if (h2[i] != m_lvl[i]) begin
          run[i]++;
          if (run[i] == DEB) begin
            m_lvl[i] = ~m_lvl[i];
            run[i] = 0;
          end
        end else run[i] = 0;
      end
      h2 = h1;
      h1 = btn;
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dir", dir, m_dir);
      chk("dir_changed", dir_changed, m_chg);
      chk("started", started, m_started);
      chk("btn_level", btn_level, m_lvl);
      chk("q_count", q_count, mq.size());
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rst_pulse();
    rst = 1;
    tick();
    rst = 0;
  endtask
  task automatic do_step();
    step = 1;
    tick();
    step = 0;
  endtask
  // hold a button until its press event, optionally stepping in that same cycle, then release
  task automatic press(input int idx, input bit with_step);
    btn[idx] = 1;
    repeat (6) tick();
    step = with_step;
    tick();
    step = 0;
    btn[idx] = 0;
    repeat (7) tick();
  endtask
  initial begin
    tick();
    chk_en = 1;
    tick();
    rst = 0;
    repeat (20) tick();
    chk("idle_dir", dir, 2'b01);
    chk("idle_started", started, 0);
    chk("idle_q", q_count, 0);
    btn[0] = 1;
    repeat (5) tick();
    chk("deb_early", btn_level[0], 0);
    tick();
    chk("deb_rise", btn_level[0], 1);
    repeat (4) tick();
    chk("up_q", q_count, 1);
    chk("up_started", started, 1);
    btn[0] = 0;
    do_step();
    chk("up_dir", dir, 2'b00);
    chk("up_pulse", dir_changed, 1);
    tick();
    chk("up_pulse_end", dir_changed, 0);
    chk("up_q0", q_count, 0);
    repeat (8) tick();
    for (int i = 0; i < 10; i++) begin
      btn[0] = ~btn[0];
      repeat (2) tick();
    end
    chk("bounce_lvl", btn_level, 0);
    chk("bounce_q", q_count, 0);
    rst_pulse();
    press(3, 0);
    chk("rev_q", q_count, 0);
    chk("rev_started", started, 0);
    press(0, 0);
    press(3, 0);
    press(2, 0);
    chk("full_q", q_count, 2);
    chk("full_dir", dir, 2'b01);
    do_step();
    chk("pop1_dir", dir, 2'b00);
    do_step();
    chk("pop2_dir", dir, 2'b11);
    rst_pulse();
    press(0, 0);
    press(3, 0);
    press(1, 1);
    chk("same_rev_dir", dir, 2'b00);
    chk("same_rev_q", q_count, 1);
    rst_pulse();
    press(0, 0);
    press(3, 0);
    press(2, 1);
    chk("same_acc_dir", dir, 2'b00);
    chk("same_acc_q", q_count, 2);
    rst_pulse();
    chk("rst_q", q_count, 0);
    chk("rst_dir", dir, 2'b01);
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 40) == 0) rst_pulse();
      btn = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'b0;
      for (int n = $urandom_range(1, 12); n > 0; n--) begin
        step = $urandom_range(0, 3) == 0;
        tick();
      end
      step = 0;
    end
    btn = '0;
    repeat (10) tick();
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
